sky_execute_stage: RTL and testbench

- Execute stage of the XU pipeline; sits between decode/register-read and the memory stage.
- Computes single-cycle ALU results and load/store effective addresses.
- Runs an iterative 32-cycle multiply/divide engine and back-pressures upstream with ex_busy while it is running.
- Registers all results and writeback control into the EX/MEM pipeline register that feeds the memory stage.

---
 rtl/sky_execute_stage.sv | 203 ++++++++++++++++++++
 tb/tb_sky_execute_stage.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sky_execute_stage.sv
// XU execute stage: single-cycle ALU, load/store address generation and the EX/MEM register.
// Defining SKY_EX_MULDIV_EN adds the iterative 32-cycle MUL/DIVU/REMU engine and its FSM.
module sky_execute_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  valid_in,
  input  logic [3:0]            alu_op,
  input  logic [XLEN-1:0]       operand_a,
  input  logic [XLEN-1:0]       operand_b,
  input  logic [XLEN-1:0]       imm,
  input  logic                  use_imm,
  input  logic [REG_ADDR_W-1:0] rd_addr_in,
  input  logic                  mem_read_in,
  input  logic                  mem_write_in,
  input  logic                  reg_write_in,
  output logic                  ex_busy,
  output logic                  valid_out,
  output logic [XLEN-1:0]       result_out,
  output logic [XLEN-1:0]       mem_addr,
  output logic [XLEN-1:0]       mem_write_data,
  output logic [REG_ADDR_W-1:0] wb_rd_addr_out,
  output logic                  wb_mem_read,
  output logic                  wb_mem_write,
  output logic                  wb_reg_write_out
);
  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_AND   = 4'h2;
  localparam logic [3:0] OP_OR    = 4'h3;
  localparam logic [3:0] OP_XOR   = 4'h4;
  localparam logic [3:0] OP_SLL   = 4'h5;
  localparam logic [3:0] OP_SRL   = 4'h6;
  localparam logic [3:0] OP_SRA   = 4'h7;
  localparam logic [3:0] OP_SLT   = 4'h8;
  localparam logic [3:0] OP_SLTU  = 4'h9;
  localparam logic [3:0] OP_PASSB = 4'hD;

  logic [XLEN-1:0] w_b;
  logic [4:0]      w_shamt;
  logic [XLEN-1:0] w_alu;
  logic            w_load;   // EX/MEM register updates this cycle
  logic            w_take;   // ...with the presented instruction (else a bubble)
  logic [XLEN-1:0] w_result;

  assign w_b     = use_imm ? imm : operand_b;
  assign w_shamt = w_b[4:0];

  always_comb begin
    w_alu = '0;
    case (alu_op)
      OP_ADD:   w_alu = operand_a + w_b;
      OP_SUB:   w_alu = operand_a - w_b;
      OP_AND:   w_alu = operand_a & w_b;
      OP_OR:    w_alu = operand_a | w_b;
      OP_XOR:   w_alu = operand_a ^ w_b;
      OP_SLL:   w_alu = operand_a << w_shamt;
      OP_SRL:   w_alu = operand_a >> w_shamt;
      OP_SRA:   w_alu = $signed(operand_a) >>> w_shamt;
      OP_SLT:   w_alu = {{(XLEN-1){1'b0}}, ($signed(operand_a) < $signed(w_b))};
      OP_SLTU:  w_alu = {{(XLEN-1){1'b0}}, (operand_a < w_b)};
      OP_PASSB: w_alu = w_b;
      default:  w_alu = '0;
    endcase
  end

`ifdef SKY_EX_MULDIV_EN
  localparam logic [3:0] OP_MUL  = 4'hA;
  localparam logic [3:0] OP_DIVU = 4'hB;
  localparam logic [3:0] OP_REMU = 4'hC;

  typedef enum logic [1:0] {S_IDLE, S_MUL_RUN, S_DIV_RUN, S_DONE} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [4:0]      r_cnt;
  logic [3:0]      r_op;
  logic [XLEN-1:0] r_md_a;    // MUL: shifting multiplicand; DIV: dividend becoming quotient
  logic [XLEN-1:0] r_md_b;    // MUL: shifting multiplier;   DIV: divisor
  logic [XLEN-1:0] r_md_acc;  // MUL: product;                DIV: partial remainder
  logic            w_is_md;
  logic            w_start;
  logic [XLEN:0]   w_rem_shift;
  logic [XLEN:0]   w_rem_sub;

  assign w_is_md = (alu_op == OP_MUL) || (alu_op == OP_DIVU) || (alu_op == OP_REMU);
  assign w_start = (r_state == S_IDLE) && !flush && !stall && valid_in && w_is_md;
  assign ex_busy = (r_state == S_MUL_RUN) || (r_state == S_DIV_RUN) ||
                   ((r_state == S_IDLE) && valid_in && w_is_md);

  // Partial remainder stays below the divisor, so bit XLEN of the difference is a clean borrow.
  assign w_rem_shift = {r_md_acc, r_md_a[XLEN-1]};
  assign w_rem_sub   = w_rem_shift - {1'b0, r_md_b};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b1;
    w_take       = 1'b0;
    w_result     = w_alu;
    if (!flush) begin
      case (r_state)
        S_IDLE: begin
          w_load = !stall;
          w_take = valid_in && !w_is_md;
          if (w_start) w_state_next = (alu_op == OP_MUL) ? S_MUL_RUN : S_DIV_RUN;
        end
        S_MUL_RUN, S_DIV_RUN: begin
          w_load = !stall;
          if (r_cnt == 5'd31) w_state_next = S_DONE;
        end
        S_DONE: begin
          w_load   = !stall;
          w_take   = valid_in;
          w_result = (r_op == OP_DIVU) ? r_md_a : r_md_acc;
          if (!stall) w_state_next = S_IDLE;
        end
        default: w_state_next = S_IDLE;
      endcase
    end else begin
      w_state_next = S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_op     <= '0;
      r_md_a   <= '0;
      r_md_b   <= '0;
      r_md_acc <= '0;
    end else if (w_start) begin
      r_cnt    <= '0;
      r_op     <= alu_op;
      r_md_a   <= operand_a;
      r_md_b   <= w_b;
      r_md_acc <= '0;
    end else if (!flush && ((r_state == S_MUL_RUN) || (r_state == S_DIV_RUN))) begin
      r_cnt <= r_cnt + 5'd1;
      if (r_state == S_MUL_RUN) begin
        if (r_md_b[0]) r_md_acc <= r_md_acc + r_md_a;
        r_md_a <= r_md_a << 1;
        r_md_b <= r_md_b >> 1;
      end else if (!w_rem_sub[XLEN]) begin
        r_md_acc <= w_rem_sub[XLEN-1:0];
        r_md_a   <= {r_md_a[XLEN-2:0], 1'b1};
      end else begin
        r_md_acc <= w_rem_shift[XLEN-1:0];
        r_md_a   <= {r_md_a[XLEN-2:0], 1'b0};
      end
    end
  end
`else
  assign ex_busy = 1'b0;

  always_comb begin
    w_load   = flush || !stall;
    w_take   = !flush && valid_in;
    w_result = w_alu;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_out        <= 1'b0;
      result_out       <= '0;
      mem_addr         <= '0;
      mem_write_data   <= '0;
      wb_rd_addr_out   <= '0;
      wb_mem_read      <= 1'b0;
      wb_mem_write     <= 1'b0;
      wb_reg_write_out <= 1'b0;
    end else if (w_load) begin
      if (w_take) begin
        valid_out        <= 1'b1;
        result_out       <= w_result;
        mem_addr         <= operand_a + imm;
        mem_write_data   <= operand_b;
        wb_rd_addr_out   <= rd_addr_in;
        wb_mem_read      <= mem_read_in;
        wb_mem_write     <= mem_write_in;
        wb_reg_write_out <= reg_write_in;
      end else begin
        valid_out        <= 1'b0;
        result_out       <= '0;
        mem_addr         <= '0;
        mem_write_data   <= '0;
        wb_rd_addr_out   <= '0;
        wb_mem_read      <= 1'b0;
        wb_mem_write     <= 1'b0;
        wb_reg_write_out <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sky_execute_stage.sv
// Directed self-checking bench for sky_execute_stage (engine tests when SKY_EX_MULDIV_EN is defined).
module tb_sky_execute_stage;
  logic        clk = 1'b0;
  logic        reset, stall, flush, valid_in, use_imm;
  logic [3:0]  alu_op, rd_addr_in;
  logic [31:0] operand_a, operand_b, imm;
  logic        mem_read_in, mem_write_in, reg_write_in;
  logic        ex_busy, valid_out, wb_mem_read, wb_mem_write, wb_reg_write_out;
  logic [31:0] result_out, mem_addr, mem_write_data;
  logic [3:0]  wb_rd_addr_out;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef SKY_EX_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  sky_execute_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .valid_in(valid_in),
    .alu_op(alu_op), .operand_a(operand_a), .operand_b(operand_b), .imm(imm),
    .use_imm(use_imm), .rd_addr_in(rd_addr_in), .mem_read_in(mem_read_in),
    .mem_write_in(mem_write_in), .reg_write_in(reg_write_in), .ex_busy(ex_busy),
    .valid_out(valid_out), .result_out(result_out), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .wb_rd_addr_out(wb_rd_addr_out),
    .wb_mem_read(wb_mem_read), .wb_mem_write(wb_mem_write),
    .wb_reg_write_out(wb_reg_write_out)
  );

  // ALU tables: row set 1 uses operand_b, row set 2 uses imm with operand_b = all ones.
  logic [3:0]  t_op   [13] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hD, 4'hE, 4'hF};
  logic [31:0] t_exp1 [13] = '{32'h80000004, 32'h7FFFFFFC, 32'h00000000, 32'h80000004, 32'h80000004,
                               32'h00000000, 32'h08000000, 32'hF8000000, 32'h00000001, 32'h00000000,
                               32'h00000004, 32'h00000000, 32'h00000000};
  logic [31:0] t_exp2 [13] = '{32'h2143657B, 32'h03254775, 32'h02040600, 32'h1F3F5F7B, 32'h1D3B597B,
                               32'h91A2B3C0, 32'h02468ACF, 32'h02468ACF, 32'h00000000, 32'h00000000,
                               32'h0F0F0F03, 32'h00000000, 32'h00000000};

  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] im, input logic ui, input logic [3:0] rd,
                       input logic mr, input logic mw, input logic rw);
    valid_in = v; alu_op = op; operand_a = a; operand_b = b; imm = im; use_imm = ui;
    rd_addr_in = rd; mem_read_in = mr; mem_write_in = mw; reg_write_in = rw;
  endtask

  task automatic bubble();
    drive(1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, 4'h0, 32'h11, 32'h22, 32'h33, 1'b0, 4'd5, 1'b1, 1'b1, 1'b1);
    tick(); tick();
    n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", valid_out); end
    n_cmp++; if (result_out !== 32'h0) begin n_bad++; $display("FAIL reset_result: got %h want 0", result_out); end
    n_cmp++; if (wb_reg_write_out !== 1'b0) begin n_bad++; $display("FAIL reset_regwrite: got %b want 0", wb_reg_write_out); end
    n_cmp++; if (ex_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", ex_busy); end
    reset = 1'b0;
    tick();
    n_cmp++; if (result_out !== 32'h33) begin n_bad++; $display("FAIL post_reset_add: got %h want 33", result_out); end
    n_cmp++; if (mem_addr !== 32'h44) begin n_bad++; $display("FAIL post_reset_addr: got %h want 44", mem_addr); end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL async_reset_valid: got %b want 0", valid_out); end
    n_cmp++; if (result_out !== 32'h0) begin n_bad++; $display("FAIL async_reset_result: got %h want 0", result_out); end
    n_cmp++; if (mem_write_data !== 32'h0) begin n_bad++; $display("FAIL async_reset_wdata: got %h want 0", mem_write_data); end
    reset = 1'b0;
    bubble();
    tick();
  endtask

  task automatic test_add();
    drive(1'b1, 4'h0, 32'd5, 32'h0, 32'hFFFFFFFD, 1'b1, 4'd3, 1'b0, 1'b0, 1'b1);
    #1;
    n_cmp++; if (ex_busy !== 1'b0) begin n_bad++; $display("FAIL add_busy: got %b want 0", ex_busy); end
    tick();
    n_cmp++; if (result_out !== 32'd2) begin n_bad++; $display("FAIL add_result: got %h want 2", result_out); end
    n_cmp++; if (wb_rd_addr_out !== 4'd3) begin n_bad++; $display("FAIL add_rd: got %0d want 3", wb_rd_addr_out); end
    n_cmp++; if (valid_out !== 1'b1) begin n_bad++; $display("FAIL add_valid: got %b want 1", valid_out); end
    n_cmp++; if (wb_reg_write_out !== 1'b1) begin n_bad++; $display("FAIL add_regwrite: got %b want 1", wb_reg_write_out); end
  endtask

  task automatic test_load_store();
    drive(1'b1, 4'h0, 32'h1000, 32'hCAFEF00D, 32'h10, 1'b1, 4'd9, 1'b1, 1'b0, 1'b1);
    tick();
    n_cmp++; if (mem_addr !== 32'h1010) begin n_bad++; $display("FAIL load_addr: got %h want 1010", mem_addr); end
    n_cmp++; if (wb_mem_read !== 1'b1) begin n_bad++; $display("FAIL load_memread: got %b want 1", wb_mem_read); end
    n_cmp++; if (wb_mem_write !== 1'b0) begin n_bad++; $display("FAIL load_memwrite: got %b want 0", wb_mem_write); end
    drive(1'b1, 4'h0, 32'h2000, 32'hDEADBEEF, 32'hFFFFFFFC, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0);
    tick();
    n_cmp++; if (mem_addr !== 32'h1FFC) begin n_bad++; $display("FAIL store_addr: got %h want 1ffc", mem_addr); end
    n_cmp++; if (mem_write_data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL store_data: got %h want deadbeef", mem_write_data); end
    n_cmp++; if (wb_mem_write !== 1'b1) begin n_bad++; $display("FAIL store_memwrite: got %b want 1", wb_mem_write); end
    n_cmp++; if (wb_reg_write_out !== 1'b0) begin n_bad++; $display("FAIL store_regwrite: got %b want 0", wb_reg_write_out); end
  endtask

  task automatic test_alu_ops();
    for (int i = 0; i < 13; i++) begin
      drive(1'b1, t_op[i], 32'h80000000, 32'd4, 32'h100, 1'b0, 4'd1, 1'b0, 1'b0, 1'b1);
      tick();
      n_cmp++; if (result_out !== t_exp1[i]) begin n_bad++; $display("FAIL alu1_op%h: got %h want %h", t_op[i], result_out, t_exp1[i]); end
    end
    n_cmp++; if (mem_addr !== 32'h80000100) begin n_bad++; $display("FAIL alu1_addr: got %h want 80000100", mem_addr); end
    for (int i = 0; i < 13; i++) begin
      drive(1'b1, t_op[i], 32'h12345678, 32'hFFFFFFFF, 32'h0F0F0F03, 1'b1, 4'd2, 1'b0, 1'b0, 1'b1);
      tick();
      n_cmp++; if (result_out !== t_exp2[i]) begin n_bad++; $display("FAIL alu2_op%h: got %h want %h", t_op[i], result_out, t_exp2[i]); end
    end
  endtask

  task automatic test_bubble();
    drive(1'b0, 4'h0, 32'h1, 32'h1, 32'h1, 1'b1, 4'd3, 1'b1, 1'b1, 1'b1);
    tick();
    n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL bubble_valid: got %b want 0", valid_out); end
    n_cmp++; if (wb_reg_write_out !== 1'b0) begin n_bad++; $display("FAIL bubble_regwrite: got %b want 0", wb_reg_write_out); end
    n_cmp++; if (wb_mem_read !== 1'b0) begin n_bad++; $display("FAIL bubble_memread: got %b want 0", wb_mem_read); end
  endtask

  task automatic test_stall_idle();
    drive(1'b1, 4'h0, 32'd1, 32'd1, 32'h0, 1'b0, 4'd6, 1'b0, 1'b0, 1'b1);
    tick();
    stall = 1'b1;
    drive(1'b1, 4'h0, 32'd5, 32'd5, 32'h0, 1'b0, 4'd8, 1'b0, 1'b0, 1'b1);
    tick();
    n_cmp++; if (result_out !== 32'd2) begin n_bad++; $display("FAIL stall_hold_result: got %h want 2", result_out); end
    n_cmp++; if (wb_rd_addr_out !== 4'd6) begin n_bad++; $display("FAIL stall_hold_rd: got %0d want 6", wb_rd_addr_out); end
    drive(1'b1, 4'hA, 32'd7, 32'd6, 32'h0, 1'b0, 4'd7, 1'b0, 1'b0, 1'b1);
    #1;
    n_cmp++; if (ex_busy !== MD_EN) begin n_bad++; $display("FAIL stall_md_busy: got %b want %b", ex_busy, MD_EN); end
    tick();
    n_cmp++; if (valid_out !== 1'b1 || result_out !== 32'd2) begin n_bad++; $display("FAIL stall_md_hold: got %b/%h want 1/2", valid_out, result_out); end
    bubble();
    stall = 1'b0;
    tick();
    n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL stall_release_bubble: got %b want 0", valid_out); end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  ops [5] = '{4'h9, 4'h8, 4'h1, 4'h0, 4'h8};
    logic [31:0] as  [5] = '{32'd1, 32'd1, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] bs  [5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'd1, 32'd1};
    logic [31:0] exp [5] = '{32'd1, 32'd0, 32'hFFFFFFFF, 32'd0, 32'd1};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, ops[i], as[i], bs[i], 32'h0, 1'b0, 4'(i + 1), 1'b0, 1'b0, 1'b1);
      tick();
      n_cmp++; if (result_out !== exp[i]) begin n_bad++; $display("FAIL b2b_%0d_result: got %h want %h", i, result_out, exp[i]); end
      n_cmp++; if (wb_rd_addr_out !== 4'(i + 1)) begin n_bad++; $display("FAIL b2b_%0d_rd: got %0d want %0d", i, wb_rd_addr_out, i + 1); end
    end
    bubble();
    tick();
  endtask

  task automatic test_flush();
    stall = 1'b1;
    flush = 1'b1;
    drive(1'b1, 4'h0, 32'd3, 32'd4, 32'h0, 1'b0, 4'd2, 1'b0, 1'b0, 1'b1);
    tick();
    flush = 1'b0;
    stall = 1'b0;
    n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL flush_idle_valid: got %b want 0", valid_out); end
    bubble();
    tick();
  endtask

`ifdef SKY_EX_MULDIV_EN
  task automatic run_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int busy_n, output int lat, output logic [31:0] res);
    busy_n = 0;
    lat = -1;
    res = 32'h0;
    drive(1'b1, op, a, b, 32'h0, 1'b0, 4'd7, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 40 && lat < 0; c++) begin
      #1;
      if (ex_busy) busy_n++;
      tick();
      if (valid_out) begin lat = c + 1; res = result_out; end
    end
    bubble();
  endtask

  task automatic test_mul();
    int busy_n, lat;
    logic [31:0] res;
    run_md(4'hA, 32'd7, 32'd6, busy_n, lat, res);
    n_cmp++; if (busy_n !== 33) begin n_bad++; $display("FAIL mul_busy_cycles: got %0d want 33", busy_n); end
    n_cmp++; if (lat !== 34) begin n_bad++; $display("FAIL mul_latency: got %0d want 34", lat); end
    n_cmp++; if (res !== 32'd42) begin n_bad++; $display("FAIL mul_result: got %h want 2a", res); end
    n_cmp++; if (wb_rd_addr_out !== 4'd7 || wb_reg_write_out !== 1'b1) begin n_bad++; $display("FAIL mul_ctrl: got rd %0d rw %b want 7/1", wb_rd_addr_out, wb_reg_write_out); end
    run_md(4'hA, 32'hFFFFFFFF, 32'hFFFFFFFF, busy_n, lat, res);
    n_cmp++; if (res !== 32'd1 || lat !== 34) begin n_bad++; $display("FAIL mul_wrap: got %h lat %0d want 1 lat 34", res, lat); end
    run_md(4'hA, 32'h12345, 32'h100, busy_n, lat, res);
    n_cmp++; if (res !== 32'h1234500 || lat !== 34) begin n_bad++; $display("FAIL mul_shift: got %h lat %0d want 1234500 lat 34", res, lat); end
  endtask

  task automatic test_div();
    logic [3:0]  ops [6] = '{4'hB, 4'hC, 4'hB, 4'hC, 4'hB, 4'hC};
    logic [31:0] as  [6] = '{32'd100, 32'd100, 32'd5, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] bs  [6] = '{32'd7, 32'd7, 32'd0, 32'd0, 32'h10, 32'h10};
    logic [31:0] exp [6] = '{32'd14, 32'd2, 32'hFFFFFFFF, 32'd5, 32'h0FFFFFFF, 32'hF};
    int busy_n, lat;
    logic [31:0] res;
    for (int i = 0; i < 6; i++) begin
      run_md(ops[i], as[i], bs[i], busy_n, lat, res);
      n_cmp++; if (res !== exp[i] || lat !== 34) begin n_bad++; $display("FAIL div_%0d_op%h: got %h lat %0d want %h lat 34", i, ops[i], res, lat, exp[i]); end
    end
  endtask

  task automatic test_done_stall();
    drive(1'b1, 4'hA, 32'd7, 32'd6, 32'h0, 1'b0, 4'd4, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 33; c++) tick();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++; if (ex_busy !== 1'b0) begin n_bad++; $display("FAIL done_stall_busy_%0d: got %b want 0", k, ex_busy); end
      tick();
      n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL done_stall_hold_%0d: got %b want 0", k, valid_out); end
    end
    stall = 1'b0;
    tick();
    n_cmp++; if (valid_out !== 1'b1 || result_out !== 32'd42) begin n_bad++; $display("FAIL done_stall_result: got %b/%h want 1/2a", valid_out, result_out); end
    bubble();
    tick();
  endtask

  task automatic test_flush_md();
    int seen;
    drive(1'b1, 4'hA, 32'd7, 32'd6, 32'h0, 1'b0, 4'd4, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 10; c++) tick();
    flush = 1'b1;
    bubble();
    tick();
    flush = 1'b0;
    n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL flush_run_valid: got %b want 0", valid_out); end
    n_cmp++; if (ex_busy !== 1'b0) begin n_bad++; $display("FAIL flush_run_busy: got %b want 0", ex_busy); end
    drive(1'b1, 4'h0, 32'd1, 32'd2, 32'h0, 1'b0, 4'd9, 1'b0, 1'b0, 1'b1);
    tick();
    n_cmp++; if (valid_out !== 1'b1 || result_out !== 32'd3) begin n_bad++; $display("FAIL flush_then_add: got %b/%h want 1/3", valid_out, result_out); end
    bubble();
    seen = 0;
    for (int c = 0; c < 30; c++) begin tick(); if (valid_out) seen++; end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL flush_no_stale: got %0d valid cycles want 0", seen); end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 4'hB, 32'd100, 32'd7, 32'h0, 1'b0, 4'd4, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 20; c++) tick();
    reset = 1'b1;
    bubble();
    #1;
    n_cmp++; if (ex_busy !== 1'b0) begin n_bad++; $display("FAIL reset_mid_busy: got %b want 0", ex_busy); end
    n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL reset_mid_valid: got %b want 0", valid_out); end
    #2 reset = 1'b0;
    drive(1'b1, 4'h0, 32'd10, 32'd20, 32'h0, 1'b0, 4'd2, 1'b0, 1'b0, 1'b1);
    tick();
    n_cmp++; if (valid_out !== 1'b1 || result_out !== 32'd30) begin n_bad++; $display("FAIL reset_mid_add: got %b/%h want 1/1e", valid_out, result_out); end
    bubble();
    tick();
  endtask
`else
  task automatic test_muldiv_disabled();
    logic [3:0] ops [3] = '{4'hA, 4'hB, 4'hC};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, ops[i], 32'd100, 32'd7, 32'h0, 1'b0, 4'd5, 1'b0, 1'b0, 1'b1);
      #1;
      n_cmp++; if (ex_busy !== 1'b0) begin n_bad++; $display("FAIL nomd_busy_op%h: got %b want 0", ops[i], ex_busy); end
      tick();
      n_cmp++; if (valid_out !== 1'b1 || result_out !== 32'h0) begin n_bad++; $display("FAIL nomd_result_op%h: got %b/%h want 1/0", ops[i], valid_out, result_out); end
    end
    bubble();
    tick();
  endtask
`endif

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    bubble();
    test_reset();
    test_add();
    test_load_store();
    test_alu_ops();
    test_bubble();
    test_stall_idle();
    test_back_to_back();
    test_flush();
`ifdef SKY_EX_MULDIV_EN
    test_mul();
    test_div();
    test_done_stall();
    test_flush_md();
    test_reset_mid();
`else
    test_muldiv_disabled();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
